fetch_unit: RTL
===============

FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 Parameter XLEN, default 64, address/PC width.
REQ-002 Parameter ILEN, default 32, instruction width.
REQ-003 Parameter PC_ENTRY, default 64'h80000000, reset fetch address.
REQ-004 Parameter FQ_DEPTH, default 4, fetch-queue entries; power of two, >=2.
REQ-005 clk  in  1  clock; all state updates on posedge.
REQ-006 rst  in  1  reset, synchronous, active-high.
REQ-007 ex  in  1  exception redirect request.
REQ-008 ex_entry  in  XLEN  exception handler address.
REQ-009 ex_ret  in  1  exception-return redirect request.
REQ-010 epc  in  XLEN  exception-return address.
REQ-011 br_taken  in  1  branch redirect request.
REQ-012 br_target  in  XLEN  branch target address.
REQ-013 imem_req_valid  out  1  fetch request valid.
REQ-014 imem_req_ready  in  1  memory accepts request.
REQ-015 imem_req_addr  out  XLEN  fetch address.
REQ-016 imem_resp_valid  in  1  response valid; in order, one per accepted request, no backpressure.
REQ-017 imem_resp_data  in  ILEN  fetched instruction.
REQ-018 inst_valid  out  1  queue head valid.
REQ-019 inst_ready  in  1  downstream pops head.
REQ-020 inst_pc  out  XLEN  PC of head instruction.
REQ-021 inst  out  ILEN  head instruction.

Function
REQ-022 Redirect = ex | ex_ret | br_taken; target priority ex_entry > epc > br_target.
REQ-023 FSM states: REQ (may issue), WAIT (one request outstanding), DROP (outstanding response to be discarded); at most one outstanding request.
REQ-024 imem_req_valid = (state==REQ) & (count<FQ_DEPTH) & ~redirect; imem_req_addr = fetch_pc; handshake moves REQ->WAIT.
REQ-025 In WAIT, imem_resp_valid pushes {fetch_pc, imem_resp_data} to queue tail, fetch_pc <= fetch_pc+4 (mod 2^XLEN), state -> REQ.
REQ-026 Redirect in REQ: fetch_pc <= target, queue flushed, state stays REQ.
REQ-027 Redirect in WAIT without response: flush, fetch_pc <= target, -> DROP; with response same cycle: response discarded, flush, fetch_pc <= target, -> REQ.
REQ-028 In DROP: response discarded, -> REQ; redirect in DROP updates fetch_pc, flushes, and stays DROP unless response arrives the same cycle (then -> REQ).
REQ-029 Queue: FIFO, pointers wrap modulo FQ_DEPTH; inst_valid = count!=0; pop when inst_valid & inst_ready.
REQ-030 Push and pop in the same cycle allowed, including when full; count unchanged.
REQ-031 Redirect cycle: a pop in that cycle completes on the current head; flush takes effect next cycle (inst_valid=0); flush overrides any same-cycle push.
REQ-032 Instruction latency: response in cycle N -> inst_valid in N+1 (registered queue, no bypass).
REQ-033 Target addresses passed unmodified; no alignment check.

Reset
REQ-034 rst: fetch_pc=PC_ENTRY, state=REQ, queue empty, pointers 0; imem_req_valid=0 and inst_valid=0 during reset; inst_pc/inst don't-care while inst_valid=0.
REQ-035 rst mid-transaction: outstanding response after reset is not tracked; memory shares rst and drops it.

Structure
REQ-036 Shared package holds PC_ENTRY default and the FSM state enum (REQ/WAIT/DROP).
REQ-037 One sub-module: fetch_queue (parametrised FIFO with flush), instantiated once.

Verification
REQ-038 Reset release, req_ready=1, one-cycle response latency -> addresses 0x80000000, 0x80000004, ... in order; inst_pc matches.
REQ-039 inst_ready=0 -> exactly FQ_DEPTH (4) entries queued, then imem_req_valid=0; one pop -> exactly one new request.
REQ-040 br_taken to 0x80001000 while WAIT, response two cycles later -> response dropped, next request addr 0x80001000, no stale inst_valid.
REQ-041 ex, ex_ret, br_taken together (ex_entry=0x80000100) -> next request 0x80000100; ex_ret+br_taken -> epc used.
REQ-042 Full queue with push and pop same cycle -> count stays 4, order preserved; pointer wrap after 9 pushes -> correct order.
REQ-043 rst asserted in WAIT -> next cycle inst_valid=0, first request 0x80000000.

Source files
------------

// File: rtl/fetch_unit_pkg.sv
// rtl/fetch_unit_pkg.sv - shared fetch-unit constants and FSM state encoding
package fetch_unit_pkg;

  localparam logic [63:0] PC_ENTRY_DEFAULT = 64'h0000_0000_8000_0000;

  typedef enum logic [1:0] {
    S_REQ  = 2'd0,
    S_WAIT = 2'd1,
    S_DROP = 2'd2
  } fetch_state_e;

endpackage

// File: rtl/fetch_unit_if.sv
// rtl/fetch_unit_if.sv - redirect, instruction-memory and instruction-out bundle
interface fetch_unit_if #(
  parameter int XLEN = 64,
  parameter int ILEN = 32
);
  logic            ex;
  logic [XLEN-1:0] ex_entry;
  logic            ex_ret;
  logic [XLEN-1:0] epc;
  logic            br_taken;
  logic [XLEN-1:0] br_target;
  logic            imem_req_valid;
  logic            imem_req_ready;
  logic [XLEN-1:0] imem_req_addr;
  logic            imem_resp_valid;
  logic [ILEN-1:0] imem_resp_data;
  logic            inst_valid;
  logic            inst_ready;
  logic [XLEN-1:0] inst_pc;
  logic [ILEN-1:0] inst;

  modport master (
    input  ex, ex_entry, ex_ret, epc, br_taken, br_target,
    input  imem_req_ready, imem_resp_valid, imem_resp_data, inst_ready,
    output imem_req_valid, imem_req_addr, inst_valid, inst_pc, inst
  );

  modport slave (
    output ex, ex_entry, ex_ret, epc, br_taken, br_target,
    output imem_req_ready, imem_resp_valid, imem_resp_data, inst_ready,
    input  imem_req_valid, imem_req_addr, inst_valid, inst_pc, inst
  );
endinterface

// File: rtl/fetch_queue.sv
// rtl/fetch_queue.sv - registered {pc, instruction} FIFO with synchronous flush
module fetch_queue #(
  parameter int XLEN  = 64,
  parameter int ILEN  = 32,
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       flush_i,
  input  logic                       push_i,
  input  logic [XLEN-1:0]            push_pc_i,
  input  logic [ILEN-1:0]            push_inst_i,
  input  logic                       pop_i,
  output logic [$clog2(DEPTH):0]     count_o,
  output logic [XLEN-1:0]            head_pc_o,
  output logic [ILEN-1:0]            head_inst_o
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [PW-1:0]   rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
  logic [CW-1:0]   count_q, count_d;
  logic [XLEN-1:0] pc_mem_q   [DEPTH];
  logic [ILEN-1:0] inst_mem_q [DEPTH];
  logic            do_push, do_pop;

  // A full queue still accepts a push when the head leaves in the same cycle.
  always_comb begin
    do_pop   = pop_i & (count_q != '0);
    do_push  = push_i & ((count_q != CW'(DEPTH)) | do_pop);
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    if (flush_i) begin
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (do_pop)  rd_ptr_d = rd_ptr_q + PW'(1);
      if (do_push) wr_ptr_d = wr_ptr_q + PW'(1);
      count_d = count_q + CW'(do_push) - CW'(do_pop);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push && !flush_i) begin
      pc_mem_q[wr_ptr_q]   <= push_pc_i;
      inst_mem_q[wr_ptr_q] <= push_inst_i;
    end
  end

  assign count_o     = count_q;
  assign head_pc_o   = pc_mem_q[rd_ptr_q];
  assign head_inst_o = inst_mem_q[rd_ptr_q];
endmodule

// File: rtl/fetch_unit.sv
// rtl/fetch_unit.sv - single-outstanding instruction fetcher with redirect and fetch queue
module fetch_unit
  import fetch_unit_pkg::*;
#(
  parameter int              XLEN     = 64,
  parameter int              ILEN     = 32,
  parameter logic [XLEN-1:0] PC_ENTRY = XLEN'(PC_ENTRY_DEFAULT),
  parameter int              FQ_DEPTH = 4
) (
  input logic          clk,
  input logic          rst,
  fetch_unit_if.master bus
);
  localparam int QCW = $clog2(FQ_DEPTH) + 1;

  fetch_state_e    state_q, state_d;
  logic [XLEN-1:0] fetch_pc_q, fetch_pc_d;
  logic [XLEN-1:0] target;
  logic [QCW-1:0]  count;
  logic            redirect, req_valid, push, flush, pop;

  assign redirect = bus.ex | bus.ex_ret | bus.br_taken;
  assign target   = bus.ex ? bus.ex_entry : (bus.ex_ret ? bus.epc : bus.br_target);

  // DROP exists so a response belonging to a pre-redirect request never reaches the queue.
  always_comb begin
    state_d    = state_q;
    fetch_pc_d = fetch_pc_q;
    push       = 1'b0;
    flush      = 1'b0;
    req_valid  = ~rst & (state_q == S_REQ) & (count < QCW'(FQ_DEPTH)) & ~redirect;
    case (state_q)
      S_REQ: begin
        if (redirect) begin
          flush      = 1'b1;
          fetch_pc_d = target;
        end else if (req_valid && bus.imem_req_ready) begin
          state_d = S_WAIT;
        end
      end
      S_WAIT: begin
        if (redirect) begin
          flush      = 1'b1;
          fetch_pc_d = target;
          state_d    = bus.imem_resp_valid ? S_REQ : S_DROP;
        end else if (bus.imem_resp_valid) begin
          push       = 1'b1;
          fetch_pc_d = fetch_pc_q + XLEN'(4);
          state_d    = S_REQ;
        end
      end
      S_DROP: begin
        if (redirect) begin
          flush      = 1'b1;
          fetch_pc_d = target;
        end
        if (bus.imem_resp_valid) state_d = S_REQ;
      end
      default: state_d = S_REQ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_REQ;
      fetch_pc_q <= PC_ENTRY;
    end else begin
      state_q    <= state_d;
      fetch_pc_q <= fetch_pc_d;
    end
  end

  assign bus.inst_valid     = ~rst & (count != '0);
  assign pop                = bus.inst_valid & bus.inst_ready;
  assign bus.imem_req_valid = req_valid;
  assign bus.imem_req_addr  = fetch_pc_q;

  fetch_queue #(
    .XLEN  (XLEN),
    .ILEN  (ILEN),
    .DEPTH (FQ_DEPTH)
  ) u_queue (
    .clk         (clk),
    .rst         (rst),
    .flush_i     (flush),
    .push_i      (push),
    .push_pc_i   (fetch_pc_q),
    .push_inst_i (bus.imem_resp_data),
    .pop_i       (pop),
    .count_o     (count),
    .head_pc_o   (bus.inst_pc),
    .head_inst_o (bus.inst)
  );
endmodule
